// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass, zeroed entry 0
// and a sequential clear engine that scrubs the array after reset.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   init_req,
  output logic                   ready,
  input  logic                   we0,
  input  logic [AW-1:0]          waddr0,
  input  logic [XLEN-1:0]        wdata0,
  input  logic                   we1,
  input  logic [AW-1:0]          waddr1,
  input  logic [XLEN-1:0]        wdata1,
  input  logic [NUM_RD*AW-1:0]   raddr,
  output logic [NUM_RD*XLEN-1:0] rdata
);

  typedef enum logic {S_INIT, S_RUN} state_t;

  localparam logic [AW:0]   LP_NREG = (AW+1)'(NREG);
  localparam logic [AW-1:0] LP_LAST = AW'(NREG - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_clr_cnt;
  logic [AW-1:0]   w_clr_cnt_nxt;
  logic            r_ready;
  logic            w_ready_nxt;
  logic            w_clr_we;
  logic            w_run_we;
  logic            w_wr0;
  logic            w_wr1;
  logic [XLEN-1:0] r_mem [NREG];

  // An address is writable/readable when in range and not the hard-wired zero
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < LP_NREG) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  // State register: async reset restarts the clear engine at entry 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_INIT;
      r_clr_cnt <= '0;
      r_ready   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
      r_ready   <= w_ready_nxt;
    end
  end

  // Next state: walk the clear counter, or restart it on init_req
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    unique case (r_state)
      S_INIT: begin
        if (r_clr_cnt == LP_LAST) begin
          w_state_nxt = S_RUN;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        end
      end
      S_RUN: begin
        if (init_req) begin
          w_state_nxt   = S_INIT;
          w_clr_cnt_nxt = '0;
        end
      end
      default: begin
        w_state_nxt   = S_INIT;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs: clear strobe, write qualifier and registered ready
  always_comb begin
    w_clr_we    = (r_state == S_INIT);
    w_run_we    = (r_state == S_RUN) && !init_req;
    w_ready_nxt = (w_state_nxt == S_RUN);
  end

  assign ready = r_ready;
  assign w_wr0 = w_run_we && we0 && addr_ok(waddr0);
  assign w_wr1 = w_run_we && we1 && addr_ok(waddr1);

  // Array update: clear engine in INIT, else port 1 overrides port 0
  always_ff @(posedge clk) begin
    if (w_clr_we) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      if (w_wr0) r_mem[waddr0] <= wdata0;
      if (w_wr1) r_mem[waddr1] <= wdata1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rd;

    assign w_ra = raddr[k*AW +: AW];

    // Read mux: INIT and invalid addresses win over bypass
    always_comb begin
      w_rd = '0;
      if (r_state == S_INIT) begin
        w_rd = '0;
      end else if (!addr_ok(w_ra)) begin
        w_rd = '0;
      end else if ((BYPASS != 0) && we1 && (waddr1 == w_ra)) begin
        w_rd = wdata1;
      end else if ((BYPASS != 0) && we0 && (waddr0 == w_ra)) begin
        w_rd = wdata0;
      end else begin
        w_rd = r_mem[w_ra];
      end
    end

    assign rdata[k*XLEN +: XLEN] = w_rd;
  end

endmodule
